// File: rtl/sine_pwm_dac_if.sv
// sine_pwm_dac_if
//   Sample stream between the sine generator (master) and the PWM DAC (slave).
//   sample       : 16-bit unsigned code, nominal 0..PERIOD
//   sample_valid : producer presents a sample; held stable while ready is low
//   sample_ready : consumer's one-entry buffer can take a sample this cycle
interface sine_pwm_dac_if;
   logic [15:0] sample;
   logic        sample_valid;
   logic        sample_ready;

   modport master (output sample, output sample_valid, input sample_ready);
   modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac
//   Fixed-period PWM DAC. Buffers one sample through a valid/ready handshake,
//   loads it as the active duty at each period boundary and flags an underrun
//   when no sample is waiting at the boundary.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   en           : run enable; when low the counter, duty and pwm_out hold
//   s_if         : sample stream (slave side)
//   pwm_out      : registered PWM, high during cnt = 0..duty-1
//   period_tick  : one-cycle pulse in the first cycle of each period
//   underrun     : pulses with period_tick when the buffer was empty
//   underrun_cnt : saturating underrun count
module sine_pwm_dac #(
   parameter int PERIOD = 2000,
   parameter int CNTW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   sine_pwm_dac_if.slave s_if,
   output logic          pwm_out,
   output logic          period_tick,
   output logic          underrun,
   output logic [15:0]   underrun_cnt
);

   localparam logic [CNTW-1:0] LAST = CNTW'(PERIOD - 1);
   localparam logic [CNTW-1:0] FULL = CNTW'(PERIOD);

   logic [CNTW-1:0] cnt, cnt_nx;
   logic [CNTW-1:0] duty, duty_nx;
   logic [CNTW-1:0] sbuf, sbuf_nx;
   logic [CNTW-1:0] sample_clamped;
   logic            buf_full, buf_full_nx;
   logic            rdy_q;
   logic            wrap, xfer;

   assign s_if.sample_ready = rdy_q;

   always_comb begin
      wrap = en && (cnt == LAST);
      xfer = s_if.sample_valid && rdy_q;
      // Compare at full width so out-of-range codes clamp even when CNTW < 16.
      sample_clamped = ({16'b0, s_if.sample} > 32'(PERIOD)) ? FULL : CNTW'(s_if.sample);

      cnt_nx      = cnt;
      duty_nx     = duty;
      sbuf_nx     = sbuf;
      buf_full_nx = buf_full;

      if (en)
         cnt_nx = wrap ? '0 : cnt + 1'b1;

      if (wrap && buf_full) begin
         duty_nx     = sbuf;
         buf_full_nx = 1'b0;
      end

      // xfer implies the buffer was empty, so it never collides with the load
      // above; a sample arriving on an empty-buffer wrap waits for the next one.
      if (xfer) begin
         sbuf_nx     = sample_clamped;
         buf_full_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         duty         <= '0;
         sbuf         <= '0;
         buf_full     <= 1'b0;
         rdy_q        <= 1'b1;
         pwm_out      <= 1'b0;
         period_tick  <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         cnt         <= cnt_nx;
         duty        <= duty_nx;
         sbuf        <= sbuf_nx;
         buf_full    <= buf_full_nx;
         // ready tracks the post-edge buffer state so it rises in the tick cycle.
         rdy_q       <= !buf_full_nx;
         if (en)
            pwm_out  <= (cnt_nx < duty_nx);
         period_tick <= wrap;
         underrun    <= wrap && !buf_full;
         if (wrap && !buf_full && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb_sine_pwm_dac
//   Table-driven startup vectors, directed corner sequences and a randomized
//   phase, all cross-checked every cycle against a queue-based reference
//   model. A second PERIOD=1 instance exercises underrun_cnt saturation.
module tb_sine_pwm_dac;
   localparam int P = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        pwm_out, period_tick, underrun;
   logic [15:0] underrun_cnt;
   sine_pwm_dac_if bus ();

   sine_pwm_dac #(.PERIOD(P), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .s_if(bus.slave),
      .pwm_out(pwm_out), .period_tick(period_tick),
      .underrun(underrun), .underrun_cnt(underrun_cnt)
   );

   logic        rst_s = 1'b1;
   logic        en_s  = 1'b1;
   logic        s_pwm, s_tick, s_ur;
   logic [15:0] s_urc;
   sine_pwm_dac_if sat_bus ();

   sine_pwm_dac #(.PERIOD(1), .CNTW(1)) sat (
      .clk(clk), .rst(rst_s), .en(en_s), .s_if(sat_bus.slave),
      .pwm_out(s_pwm), .period_tick(s_tick),
      .underrun(s_ur), .underrun_cnt(s_urc)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit sat_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // Period position as a modulo counter, the holding buffer as a queue.
   int m_pos, m_duty, m_urc;
   int m_q[$];
   bit m_ready, m_pwm, m_tick, m_ur, m_acc, m_w;
   bit chk_on = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_pos = 0; m_duty = 0; m_q.delete();
         m_ready = 1; m_pwm = 0; m_tick = 0; m_ur = 0; m_urc = 0;
         chk_on = 1;
      end else begin
         m_acc  = bus.sample_valid && m_ready;
         m_w    = en && (m_pos == P - 1);
         m_tick = m_w;
         m_ur   = m_w && (m_q.size() == 0);
         if (en) m_pos = (m_pos + 1) % P;
         if (m_w) begin
            if (m_q.size() > 0) m_duty = m_q.pop_front();
            else if (m_urc < 65535) m_urc++;
         end
         if (m_acc) m_q.push_back((int'(bus.sample) > P) ? P : int'(bus.sample));
         m_ready = (m_q.size() == 0);
         if (en) m_pwm = (m_pos < m_duty);
      end
   end

   always @(negedge clk) begin
      if (chk_on)
         chk("model", {bus.sample_ready, pwm_out, period_tick, underrun, underrun_cnt},
             {m_ready, m_pwm, m_tick, m_ur, 16'(m_urc)});
   end

   // ---------------- helpers ----------------
   task automatic send(input int v);
      bit a;
      bus.sample_valid = 1'b1;
      bus.sample       = 16'(v);
      for (int k = 0; k < 60; k++) begin
         a = bus.sample_ready;
         cyc();
         if (a) begin
            bus.sample_valid = 1'b0;
            return;
         end
      end
      bus.sample_valid = 1'b0;
      timeout("send");
   endtask

   task automatic wait_tick();
      for (int k = 0; k < 60; k++) begin
         cyc();
         if (period_tick) return;
      end
      timeout("wait_tick");
   endtask

   // Call in the tick cycle: counts pwm high cycles over the whole period.
   task automatic count_period(output int n);
      n = int'(pwm_out);
      for (int k = 1; k < P; k++) begin
         cyc();
         n += int'(pwm_out);
      end
   endtask

   // ---------------- startup vector table ----------------
   typedef struct {
      bit valid; int sample; bit en;
      bit e_ready; bit e_pwm; bit e_tick; bit e_ur;
   } vec_t;
   vec_t vt[20];

   // ---------------- saturation instance ----------------
   initial begin
      sat_bus.sample_valid = 1'b0;
      sat_bus.sample       = '0;
      repeat (3) @(negedge clk);
      chk("sat_reset", s_urc, 0);
      rst_s = 1'b0;
      for (int k = 0; k < 65540; k++) begin
         @(negedge clk);
         if (k == 99)    chk("sat_count_100", s_urc, 100);
         if (k == 65533) chk("sat_count_65534", s_urc, 65534);
      end
      chk("sat_hold", s_urc, 65535);
      chk("sat_pulse", {s_tick, s_ur, s_pwm}, 3'b110);
      sat_done = 1'b1;
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, prev, e, ticks, rdy_ok;
      bit saved;

      bus.sample_valid = 1'b0;
      bus.sample       = '0;

      vt[0] = '{1, 4, 1, 0, 0, 0, 0};
      for (int i = 1; i <= 8; i++)   vt[i] = '{0, 0, 1, 0, 0, 0, 0};
      vt[9] = '{0, 0, 1, 1, 1, 1, 0};
      for (int i = 10; i <= 12; i++) vt[i] = '{0, 0, 1, 1, 1, 0, 0};
      for (int i = 13; i <= 18; i++) vt[i] = '{0, 0, 1, 1, 0, 0, 0};
      vt[19] = '{0, 0, 1, 1, 1, 1, 1};

      repeat (3) cyc();
      chk("reset_state", {bus.sample_ready, pwm_out, period_tick, underrun, underrun_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      rst = 1'b0;

      // Sample 4 after reset: first wrap loads it, 4 high / 6 low.
      for (int i = 0; i < 20; i++) begin
         bus.sample_valid = vt[i].valid;
         bus.sample       = 16'(vt[i].sample);
         en               = vt[i].en;
         cyc();
         chk($sformatf("vec%0d", i), {bus.sample_ready, pwm_out, period_tick, underrun},
             {vt[i].e_ready, vt[i].e_pwm, vt[i].e_tick, vt[i].e_ur});
      end
      bus.sample_valid = 1'b0;

      // Clamp: 15 -> full period high, then 0 -> full period low.
      send(15);
      wait_tick();
      n = int'(pwm_out);
      bus.sample_valid = 1'b1;
      bus.sample       = 16'd0;
      cyc();
      bus.sample_valid = 1'b0;
      n += int'(pwm_out);
      repeat (P - 2) begin cyc(); n += int'(pwm_out); end
      chk("clamp15_high", n, P);
      wait_tick();
      count_period(n);
      chk("zero_low", n, 0);

      // Back-to-back 3 then 7. The 3 lands on an empty-buffer wrap edge.
      bus.sample_valid = 1'b1;
      bus.sample       = 16'd3;
      cyc();
      chk("simul_wrap_accept", {period_tick, underrun, bus.sample_ready}, 3'b110);
      bus.sample = 16'd7;
      e = 0;
      for (int k = 0; k < 60; k++) begin
         if (bus.sample_ready) begin e = 1; break; end
         cyc();
      end
      if (e == 0) timeout("stall_release");
      chk("ready_with_tick", period_tick, 1);
      n = int'(pwm_out);
      cyc();
      bus.sample_valid = 1'b0;
      chk("seven_accepted", bus.sample_ready, 0);
      n += int'(pwm_out);
      repeat (P - 2) begin cyc(); n += int'(pwm_out); end
      chk("duty3", n, 3);
      wait_tick();
      count_period(n);
      chk("duty7", n, 7);

      // Underruns: duty retained, count steps by one each period.
      prev = 0;
      for (int p = 0; p < 3; p++) begin
         wait_tick();
         chk($sformatf("underrun_pulse%0d", p), underrun, 1);
         if (p > 0) chk($sformatf("underrun_step%0d", p), underrun_cnt, 32'(prev + 1));
         prev = int'(underrun_cnt);
         count_period(n);
         chk($sformatf("retained%0d", p), n, 7);
      end

      // en low for 5 cycles mid-period.
      wait_tick();
      n = int'(pwm_out);
      repeat (3) begin cyc(); n += int'(pwm_out); end
      saved = pwm_out;
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("en_low_hold%0d", k), {pwm_out, period_tick, underrun}, {saved, 2'b00});
      end
      en = 1'b1;
      for (e = 4; e < P; e++) begin
         cyc();
         chk("resume_no_tick", period_tick, 0);
         n += int'(pwm_out);
      end
      cyc();
      chk("resume_tick", period_tick, 1);
      chk("resume_highs", n, 7);

      // Reset in cycle 5 of a duty-6 period with the buffer full.
      send(6);
      wait_tick();
      bus.sample_valid = 1'b1;
      bus.sample       = 16'd9;
      cyc();
      bus.sample_valid = 1'b0;
      chk("buf_full_ready", bus.sample_ready, 0);
      repeat (4) cyc();
      chk("pre_rst_pwm", pwm_out, 1);
      rst = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample       = 16'd5;
      cyc();
      chk("mid_rst", {bus.sample_ready, pwm_out, period_tick, underrun, underrun_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      rst = 1'b0;
      bus.sample_valid = 1'b0;
      n = 0; ticks = 0; rdy_ok = 0;
      for (int k = 0; k < 2 * P; k++) begin
         cyc();
         n      += int'(pwm_out);
         ticks  += int'(period_tick);
         rdy_ok += int'(bus.sample_ready);
      end
      chk("post_rst_pwm", n, 0);
      chk("post_rst_ticks", ticks, 2);
      chk("post_rst_ready", rdy_ok, 2 * P);

      // Randomized phase, checked by the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if (!(bus.sample_valid && !bus.sample_ready)) begin
            bus.sample_valid = ($urandom_range(0, 2) == 0);
            bus.sample = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535))
                                                     : 16'($urandom_range(0, 12));
         end
         cyc();
      end
      rst = 1'b0;
      en  = 1'b1;
      bus.sample_valid = 1'b0;

      for (int k = 0; k < 80000 && !sat_done; k++) cyc();
      if (!sat_done) timeout("sat_done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
